// File: rtl/alarm_pkg.sv
// Shared constants and FSM encoding for the alarm slot controller.
package alarm_pkg;
  localparam int DATA_W    = 13;
  localparam int NUM_SLOTS = 7;
  localparam int SEL_W     = 3;

  localparam logic [DATA_W-1:0] EMPTY_WORD = '0;

  typedef enum logic [1:0] {IDLE, WRITE, SCAN, REPORT} state_t;
endpackage

// File: rtl/slot_read_mux.sv
// Combinational NUM_SLOTS:1 select of one alarm word out of the flattened register file.
module slot_read_mux #(
  parameter int DATA_W    = 13,
  parameter int NUM_SLOTS = 7,
  parameter int SEL_W     = 3
) (
  input  logic [NUM_SLOTS*DATA_W-1:0] q_slots,
  input  logic [SEL_W-1:0]            sel,
  output logic [DATA_W-1:0]           q
);
  logic [NUM_SLOTS-1:0][DATA_W-1:0] slot_words;

  assign slot_words = q_slots;

  // Out-of-range selects read as zero, which the scanner treats as an empty slot.
  always_comb begin
    q = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (sel == SEL_W'(i)) q = slot_words[i];
  end
endmodule

// File: rtl/alarm_slot_controller.sv
// Arbitrates user slot writes against per-tick alarm scans of the 7-slot register file.
// Optional build macro SLOT_MASK_EN adds a slot_mask input that suppresses hits per slot.
module alarm_slot_controller
  import alarm_pkg::*;
(
  input  logic                        Clock,
  input  logic                        Clear,
  input  logic                        wr_req,
  input  logic [SEL_W-1:0]            wr_slot,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ack,
  output logic                        wr_err,
  input  logic                        time_tick,
  input  logic [DATA_W-1:0]           cur_time,
  input  logic [NUM_SLOTS*DATA_W-1:0] q_slots,
  output logic [SEL_W-1:0]            reg_sto,
  output logic [DATA_W-1:0]           reg_d,
  output logic                        reg_en,
  output logic                        alarm_hit,
  output logic [NUM_SLOTS-1:0]        alarm_vec,
  output logic                        tick_ovr
`ifdef SLOT_MASK_EN
  ,
  input  logic [NUM_SLOTS-1:0]        slot_mask
`endif
);
  state_t               state, state_nx;
  logic [SEL_W-1:0]     ctr;
  logic [DATA_W-1:0]    snapshot;
  logic [DATA_W-1:0]    q_sel;
  logic [NUM_SLOTS-1:0] hit;
  logic                 pending;
  logic                 slot_on;
  logic                 match;
  logic                 start_scan;
  logic                 slot_legal;

  slot_read_mux #(
    .DATA_W   (DATA_W),
    .NUM_SLOTS(NUM_SLOTS),
    .SEL_W    (SEL_W)
  ) u_mux (
    .q_slots(q_slots),
    .sel    (ctr),
    .q      (q_sel)
  );

`ifdef SLOT_MASK_EN
  assign slot_on = slot_mask[ctr];
`else
  assign slot_on = 1'b1;
`endif

  assign match      = slot_on && (q_sel == snapshot) && (q_sel != EMPTY_WORD);
  assign slot_legal = (wr_slot < SEL_W'(NUM_SLOTS));
  // A write always wins; a tick seen in the same IDLE cycle is parked as pending.
  assign start_scan = (state == IDLE) && !wr_req && (time_tick || pending);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_ack    = 1'b0;
    wr_err    = 1'b0;
    reg_en    = 1'b0;
    reg_sto   = '0;
    reg_d     = '0;
    alarm_hit = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req)                     state_nx = WRITE;
        else if (time_tick || pending)  state_nx = SCAN;
      end
      WRITE: begin
        wr_ack = 1'b1;
        if (slot_legal) begin
          reg_en  = 1'b1;
          reg_sto = wr_slot;
          reg_d   = wr_data;
        end else begin
          wr_err  = 1'b1;
        end
        state_nx = IDLE;
      end
      SCAN: begin
        if (ctr == SEL_W'(NUM_SLOTS-1)) state_nx = REPORT;
      end
      REPORT: begin
        alarm_hit = |hit;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      ctr       <= '0;
      snapshot  <= '0;
      hit       <= '0;
      pending   <= 1'b0;
      alarm_vec <= '0;
      tick_ovr  <= 1'b0;
    end else begin
      if (start_scan) begin
        snapshot <= cur_time;
        ctr      <= '0;
        hit      <= '0;
        pending  <= 1'b0;
      end else if (time_tick) begin
        // Only one tick can wait; a second one is dropped and flagged.
        if (pending) tick_ovr <= 1'b1;
        else         pending  <= 1'b1;
      end
      if (state == SCAN) begin
        hit[ctr] <= match;
        ctr      <= ctr + 1'b1;
      end
      if (state == REPORT) alarm_vec <= hit;
    end
  end
endmodule

// File: tb/tb_alarm_slot_controller.sv
// Scoreboard bench for alarm_slot_controller with a behavioural register file.
module tb_alarm_slot_controller;
  logic              Clock = 1'b0;
  logic              Clear = 1'b1;
  logic              wr_req = 1'b0;
  logic [2:0]        wr_slot = '0;
  logic [12:0]       wr_data = '0;
  logic              wr_ack, wr_err;
  logic              time_tick = 1'b0;
  logic [12:0]       cur_time = '0;
  logic [6:0][12:0]  regs = '0;
  logic [90:0]       q_slots;
  logic [2:0]        reg_sto;
  logic [12:0]       reg_d;
  logic              reg_en, alarm_hit, tick_ovr;
  logic [6:0]        alarm_vec;
`ifdef SLOT_MASK_EN
  logic [6:0]        slot_mask = 7'h7F;
`endif

  typedef struct { logic err; logic en; logic [2:0] sto; logic [12:0] d; } wr_exp_t;
  typedef struct { int due; logic hit; logic [6:0] vec; } scan_exp_t;

  wr_exp_t   wq[$];
  scan_exp_t sq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  assign q_slots = regs;
  always @(posedge Clock)
    if (reg_en && reg_sto < 3'd7) regs[reg_sto] <= reg_d;

  alarm_slot_controller dut (
    .Clock(Clock), .Clear(Clear),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .time_tick(time_tick), .cur_time(cur_time), .q_slots(q_slots),
    .reg_sto(reg_sto), .reg_d(reg_d), .reg_en(reg_en),
    .alarm_hit(alarm_hit), .alarm_vec(alarm_vec), .tick_ovr(tick_ovr)
`ifdef SLOT_MASK_EN
    , .slot_mask(slot_mask)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write ack or a due report.
  logic       vec_due = 1'b0;
  logic [6:0] vec_exp = '0;
  always @(negedge Clock) begin : mon
    wr_exp_t   w;
    scan_exp_t s;
    if (Clear) vec_due = 1'b0;
    else begin
      if (vec_due) begin
        chk("alarm_vec", 32'(alarm_vec), 32'(vec_exp));
        vec_due = 1'b0;
      end
      if (wr_ack) begin
        if (wq.size() == 0) flag("wr_ack_unexpected");
        else begin
          w = wq.pop_front();
          chk("wr_err", 32'(wr_err), 32'(w.err));
          chk("reg_en", 32'(reg_en), 32'(w.en));
          chk("reg_sto", 32'(reg_sto), 32'(w.sto));
          chk("reg_d", 32'(reg_d), 32'(w.d));
        end
      end else begin
        chk("port_quiet", 32'({reg_en, wr_err, reg_sto, reg_d}), 32'd0);
      end
      if (sq.size() != 0 && sq[0].due == cyc) begin
        s = sq.pop_front();
        chk("alarm_hit", 32'(alarm_hit), 32'(s.hit));
        vec_exp = s.vec;
        vec_due = 1'b1;
      end else begin
        chk("alarm_hit_spurious", 32'(alarm_hit), 32'd0);
        if (sq.size() != 0 && sq[0].due < cyc) begin
          void'(sq.pop_front());
          flag("scan_report_missed");
        end
      end
    end
  end

  task automatic wait_ack();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (wr_ack) break;
    end
    if (i == 50) flag("wr_ack_timeout");
    @(posedge Clock); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] slot, input logic [12:0] data, input logic err);
    @(posedge Clock); #1;
    wq.push_back('{err: err, en: !err, sto: err ? 3'd0 : slot, d: err ? 13'd0 : data});
    wr_slot = slot;
    wr_data = data;
    wr_req  = 1'b1;
    wait_ack();
  endtask

  // Tick sampled at the next edge N; report lands after edge N+7.
  task automatic do_tick(input logic [6:0] vec);
    @(posedge Clock); #1;
    sq.push_back('{due: cyc + 8, hit: |vec, vec: vec});
    time_tick = 1'b1;
    @(posedge Clock); #1;
    time_tick = 1'b0;
  endtask

  initial begin
    int c;
    repeat (2) @(negedge Clock);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_reg_en", 32'(reg_en), 0);
    chk("rst_reg_sto", 32'(reg_sto), 0);
    chk("rst_reg_d", 32'(reg_d), 0);
    chk("rst_alarm_hit", 32'(alarm_hit), 0);
    chk("rst_alarm_vec", 32'(alarm_vec), 0);
    chk("rst_tick_ovr", 32'(tick_ovr), 0);
    @(posedge Clock); #1;
    Clear = 1'b0;

    do_write(3'd2, 13'h0ABC, 1'b0);
    do_write(3'd7, 13'h1FFF, 1'b1);
    do_write(3'd1, 13'h0123, 1'b0);
    do_write(3'd4, 13'h0123, 1'b0);

    cur_time = 13'h0123;
    do_tick(7'b0010010);
    repeat (12) @(posedge Clock);

    cur_time = 13'h0000;
    do_tick(7'b0000000);
    repeat (12) @(posedge Clock);

    // Write and tick together: write first, scan starts two edges later and sees slot 6.
    cur_time = 13'h0555;
    @(posedge Clock); #1;
    c = cyc;
    wq.push_back('{err: 1'b0, en: 1'b1, sto: 3'd6, d: 13'h0555});
    sq.push_back('{due: c + 10, hit: 1'b1, vec: 7'b1000000});
    wr_slot = 3'd6; wr_data = 13'h0555; wr_req = 1'b1; time_tick = 1'b1;
    @(posedge Clock); #1;
    time_tick = 1'b0;
    wait_ack();
    repeat (14) @(posedge Clock);
    #1 chk("tick_ovr_after_pending", 32'(tick_ovr), 0);

    // Three ticks across one scan: one extra scan, overflow flagged, snapshot held.
    cur_time = 13'h0123;
    @(posedge Clock); #1;
    c = cyc;
    sq.push_back('{due: c + 8, hit: 1'b1, vec: 7'b0010010});
    sq.push_back('{due: c + 17, hit: 1'b1, vec: 7'b1000000});
    time_tick = 1'b1;
    @(posedge Clock); #1; time_tick = 1'b0;
    @(posedge Clock); #1; time_tick = 1'b1;
    @(posedge Clock); #1; time_tick = 1'b0;
    @(posedge Clock); #1; time_tick = 1'b1; cur_time = 13'h0555;
    @(posedge Clock); #1; time_tick = 1'b0;
    repeat (25) @(posedge Clock);
    #1 chk("tick_ovr_set", 32'(tick_ovr), 1);

    // Clear in the middle of a scan: no report, everything back to reset values.
    cur_time = 13'h0123;
    @(posedge Clock); #1; time_tick = 1'b1;
    @(posedge Clock); #1; time_tick = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Clear = 1'b1;
    @(posedge Clock); #1 Clear = 1'b0;
    @(negedge Clock);
    chk("clr_alarm_vec", 32'(alarm_vec), 0);
    chk("clr_tick_ovr", 32'(tick_ovr), 0);
    chk("clr_alarm_hit", 32'(alarm_hit), 0);
    repeat (12) @(posedge Clock);

    do_tick(7'b0010010);
    repeat (12) @(posedge Clock);

`ifdef SLOT_MASK_EN
    slot_mask = 7'b1101111;
    do_tick(7'b0000010);
    repeat (12) @(posedge Clock);
    slot_mask = 7'h7F;
`endif

    for (int i = 0; i < 100 && (sq.size() != 0 || wq.size() != 0); i++) @(posedge Clock);
    if (sq.size() != 0 || wq.size() != 0) flag("scoreboard_not_drained");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
